svm_sum_sequencer: RTL and testbench

Sequences a single shared saturating two-operand adder to reduce a stream of N_TERMS signed kernel products (alpha_i·K(x_i,x)) into one decision value and then add the bias term. It sits between the kernel/MAC stage and the classification output. It replaces a full combinational adder tree with one adder reused over N_TERMS+1 cycles. It also reports whether any intermediate step clamped.

---
 rtl/svm_sum_sequencer.sv | 119 +++++++++++
 tb/tb_svm_sum_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/svm_sum_sequencer.sv
// svm_sum_sequencer: reduces N_TERMS signed kernel products plus a bias into a
// single decision value using one shared saturating adder, reporting whether
// any intermediate step clamped.
module svm_sum_sequencer #(
  parameter int WIDTH   = 32,
  parameter int N_TERMS = 8,
  parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bias,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat_flag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_TERMS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] bias_q, bias_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH:0]   ext_sum;
  logic             pos_ovf, neg_ovf, clamp;
  logic [WIDTH-1:0] add_res;

  // Shared saturating adder: A is always the accumulator, B is the term or bias.
  // Overflow shows up as disagreement between the two top bits of the
  // sign-extended sum; bit WIDTH then tells which rail was crossed.
  always_comb begin
    opnd_b  = (state_q == BIAS) ? bias_q : in_data;
    ext_sum = {acc_q[WIDTH-1], acc_q} + {opnd_b[WIDTH-1], opnd_b};
    pos_ovf = ~ext_sum[WIDTH] &  ext_sum[WIDTH-1];
    neg_ovf =  ext_sum[WIDTH] & ~ext_sum[WIDTH-1];
    clamp   = pos_ovf | neg_ovf;
    if (pos_ovf)      add_res = MAX_POS;
    else if (neg_ovf) add_res = MAX_NEG;
    else              add_res = ext_sum[WIDTH-1:0];
  end

  // Next-state and datapath update for the reduction sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    bias_d  = bias_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bias_d  = bias;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = add_res;
          sat_d = sat_q | clamp;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = BIAS;
        end
      end
      BIAS: begin
        acc_d   = add_res;
        sat_d   = sat_q | clamp;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      bias_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      bias_q  <= bias_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Outputs are decoded straight from registers, so they stay stable under backpressure.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_sum   = acc_q;
    out_class = ~acc_q[WIDTH-1];
    sat_flag  = sat_q;
  end

endmodule

// File: tb/tb_svm_sum_sequencer.sv
// Self-checking bench for svm_sum_sequencer with WIDTH=8, N_TERMS=4.
module tb_svm_sum_sequencer;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, start, in_valid, out_ready;
  logic [W-1:0] bias, in_data;
  logic         in_ready, out_class, out_valid, sat_flag, busy;
  logic [W-1:0] out_sum;

  svm_sum_sequencer #(.WIDTH(W), .N_TERMS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_sum(out_sum), .out_class(out_class), .out_valid(out_valid),
    .out_ready(out_ready), .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [W-1:0] b;
    logic signed [W-1:0] t0, t1, t2, t3;
    logic signed [W-1:0] sum;
    logic                cls;
    logic                sat;
  } rec_t;

  rec_t vec[9];
  rec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic rec_t mk(int b, int a0, int a1, int a2, int a3, int s, bit c, bit f);
    rec_t r;
    r.b = W'(b); r.t0 = W'(a0); r.t1 = W'(a1); r.t2 = W'(a2); r.t3 = W'(a3);
    r.sum = W'(s); r.cls = c; r.sat = f;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every completed handshake must match the oldest pending job.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got out_valid with sum %0d, expected no result", $signed(out_sum));
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("out_sum", $signed(out_sum), e.sum);
        chk("out_class", out_class, e.cls);
        chk("sat_flag", sat_flag, e.sat);
      end
    end
  end

  // Drives one job; caller is positioned 1 time unit after a rising edge.
  task automatic run_job(input rec_t r, input int gap_beat, input int gap_len,
                         input int rdy_delay, input bit noise);
    logic signed [W-1:0] terms[N];
    int lat;
    int budget;
    terms[0] = r.t0; terms[1] = r.t1; terms[2] = r.t2; terms[3] = r.t3;
    exp_q.push_back(r);
    out_ready = (rdy_delay == 0);
    start = 1'b1; bias = r.b; in_valid = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    start = noise;
    bias = 8'sd55;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < N; i++) begin
      if (i == gap_beat) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid = 1'b0;
          in_data  = 8'sd99;
          chk("in_ready_gap", in_ready, 1);
          @(posedge clk); #1; lat++;
        end
      end
      in_valid = 1'b1;
      in_data  = terms[i];
      chk("in_ready_accum", in_ready, 1);
      @(posedge clk); #1; lat++;
    end
    in_valid = noise;
    in_data  = 8'sd99;
    budget = 50;
    while (!out_valid && budget > 0) begin
      @(posedge clk); #1; lat++; budget--;
    end
    if (budget == 0) begin
      chk("out_valid_timeout", 0, 1);
      exp_q.pop_front();
    end else begin
      chk("latency", lat, 6 + gap_len);
      for (int d = 0; d < rdy_delay; d++) begin
        chk("held_valid", out_valid, 1);
        chk("held_sum", $signed(out_sum), r.sum);
        @(posedge clk); #1;
      end
      start = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_handshake_valid", out_valid, 0);
      chk("post_handshake_busy", busy, 0);
      @(posedge clk); #1;
      chk("no_queued_start", busy, 0);
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    vec[0] = mk(-5,    10,   20,   -3, 7,   29, 1, 0);
    vec[1] = mk(0,    100,  100,  -50, 0,   77, 1, 1);
    vec[2] = mk(-10, -100, -100, -100, 0, -128, 0, 1);
    vec[3] = mk(127,    0,    0,    0, 0,  127, 1, 0);
    vec[4] = mk(-1,     0,    0,    0, 0,   -1, 0, 0);
    vec[5] = mk(1,    127,    1,   -1, 0,  127, 1, 1);
    vec[6] = mk(0,   -128,    0,    0, 0, -128, 0, 0);
    vec[7] = mk(0,      0,    0,    0, 0,    0, 1, 0);
    vec[8] = mk(-128, 127,    0,    0, 0,   -1, 0, 0);

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    bias = '0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", $signed(out_sum), 0);
    chk("rst_out_class", out_class, 1);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // in_valid while idle must not be consumed
    in_valid = 1'b1; in_data = 8'sd50;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    foreach (vec[i]) run_job(vec[i], -1, 0, 0, 1'b0);

    // stall between beats 2 and 3, then 5 cycles of backpressure
    run_job(vec[0], 2, 3, 5, 1'b0);

    // start and in_valid asserted while busy are ignored
    run_job(vec[0], -1, 0, 2, 1'b1);

    // abort after two beats
    start = 1'b1; bias = 8'sd20;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'sd100;
    @(posedge clk); #1;
    in_data = 8'sd100;
    @(posedge clk); #1;
    rst = 1'b1; in_data = 8'sd5;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sum", $signed(out_sum), 0);
    chk("abort_sat", sat_flag, 0);
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    run_job(vec[0], -1, 0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
